// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Defines the FSM state set (CSUM only with LOADER_CHECKSUM_EN).
package loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_LOAD,
        ST_WRITE,
        ST_DONE,
        ST_ERR,
        ST_CSUM
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;
`endif

    function automatic logic [WORD_W-1:0] push_byte(
        input logic [WORD_W-1:0] w,
        input logic [BYTE_W-1:0] b
    );
        return {w[WORD_W-BYTE_W-1:0], b};
    endfunction

endpackage

// File: rtl/loader_shift.sv
// Big-endian byte-to-word shift register with 2-bit byte counter.
// Ports: clk, rst_n, clr, shift, byte_in -> word, cnt.
module loader_shift
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic [1:0]        cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (clr) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift) begin
            word <= push_byte(word, byte_in);
            cnt  <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams program bytes into instruction memory, holds CPU in reset.
// Ports: s_valid/s_data/s_last/s_ready in, start, mem_we/addr/wdata,
// cpu_rst, done, err, word_cnt. Option: LOADER_CHECKSUM_EN.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state;
    state_t            state_nx;
    logic              armed;
    logic              last_q;
    logic              clr;
    logic              shift;
    logic [WORD_W-1:0] word;
    logic [1:0]        cnt;
`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] xor_acc;
`endif

    assign shift     = s_valid & s_ready;
    assign mem_wdata = word;
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERR);
    assign cpu_rst   = (state != ST_DONE);

    loader_shift u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .shift   (shift),
        .byte_in (s_data),
        .word    (word),
        .cnt     (cnt)
    );

    // Keeps s_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        mem_we   = 1'b0;
        clr      = 1'b0;
        unique case (state)
            ST_LOAD: begin
                s_ready = armed;
                if (armed && s_valid) begin
                    if (cnt == 2'd3)
                        state_nx = ST_WRITE;
                    else if (s_last)
                        state_nx = ST_ERR;
                end
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                if (last_q)
`ifdef LOADER_CHECKSUM_EN
                    state_nx = ST_CSUM;
`else
                    state_nx = ST_DONE;
`endif
                else if (mem_addr == ADDR_MAX)
                    state_nx = ST_ERR;
                else
                    state_nx = ST_LOAD;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                s_ready = 1'b1;
                if (s_valid && cnt == 2'd3) begin
                    if (push_byte(word, s_data) == xor_acc)
                        state_nx = ST_DONE;
                    else
                        state_nx = ST_ERR;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nx = ST_LOAD;
                    clr      = 1'b1;
                end
            end
            default: state_nx = ST_LOAD;
        endcase
    end

    // Address saturates at the top word; overflow is flagged by the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
            word_cnt <= '0;
            last_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_acc  <= '0;
`endif
        end else if (clr) begin
            mem_addr <= '0;
            word_cnt <= '0;
            last_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_acc  <= '0;
`endif
        end else begin
            if (state == ST_LOAD && shift && cnt == 2'd3)
                last_q <= s_last;
            if (mem_we) begin
                word_cnt <= word_cnt + (ADDR_W+1)'(1);
                if (mem_addr != ADDR_MAX)
                    mem_addr <= mem_addr + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                xor_acc <= xor_acc ^ word;
`endif
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader (ADDR_W=2 to reach overflow).
// Expected writes are queued at stimulus time, popped on mem_we.
module tb_prog_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          start = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          err;
    logic [AW:0]   word_cnt;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [AW-1:0] exp_addr = '0;
    logic [31:0]   xor_m = '0;
    int            n_chk = 0;
    int            n_fail = 0;

    prog_loader #(.ADDR_W(AW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h",
                     tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("extra_we", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(mon_e.a));
                chk("wr_data", 64'(mem_wdata), 64'(mon_e.d));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b,
                             input bit last, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        while (!s_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("hs_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w,
                             input bit last, input int gap);
        exp_q.push_back('{a: exp_addr, d: w});
        exp_addr = exp_addr + 1'b1;
        xor_m    = xor_m ^ w;
        for (int i = 0; i < 4; i++)
            send_byte(w[31-8*i -: 8], last && i == 3, gap);
    endtask

    task automatic send_csum(input logic [31:0] c);
`ifdef LOADER_CHECKSUM_EN
        for (int i = 0; i < 4; i++)
            send_byte(c[31-8*i -: 8], 1'b0, 0);
`else
        if (c === 32'hx) $display("unused");
`endif
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done || err) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_end"}, 64'(done | err), 1);
        chk({tag, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        exp_addr = '0;
        xor_m    = '0;
        chk("st_cnt", 64'(word_cnt), 0);
        chk("st_cpu", 64'(cpu_rst), 1);
        chk("st_done", 64'(done), 0);
        chk("st_err", 64'(err), 0);
        chk("st_rdy", 64'(s_ready), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rdy", 64'(s_ready), 0);
        chk("rst_we", 64'(mem_we), 0);
        chk("rst_addr", 64'(mem_addr), 0);
        chk("rst_wd", 64'(mem_wdata), 0);
        chk("rst_cpu", 64'(cpu_rst), 1);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_cnt", 64'(word_cnt), 0);
        rst_n = 1'b1;
        #1 chk("rel_rdy0", 64'(s_ready), 0);
        @(posedge clk);
        #1 chk("rel_rdy1", 64'(s_ready), 1);

        // two-word image, no gaps
        send_word(32'h2008_0005, 1'b0, 0);
        send_word(32'h0109_5020, 1'b1, 0);
        send_csum(xor_m);
        wait_end("basic");
        chk("basic_done", 64'(done), 1);
        chk("basic_cpu", 64'(cpu_rst), 0);
        chk("basic_cnt", 64'(word_cnt), 2);
        do_start();

        // same image with s_valid low every other cycle
        send_word(32'h2008_0005, 1'b0, 1);
        send_word(32'h0109_5020, 1'b1, 1);
        send_csum(xor_m);
        wait_end("gap");
        chk("gap_done", 64'(done), 1);
        chk("gap_cnt", 64'(word_cnt), 2);
        do_start();

        // s_last on byte 2 of a word
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b1, 0);
        wait_end("part");
        chk("part_err", 64'(err), 1);
        chk("part_cpu", 64'(cpu_rst), 1);
        chk("part_cnt", 64'(word_cnt), 0);
        do_start();

        // fill all 4 words without s_last
        for (int k = 0; k < 4; k++)
            send_word(32'hC0DE_0000 + k, 1'b0, 0);
        wait_end("ovf");
        chk("ovf_err", 64'(err), 1);
        chk("ovf_cnt", 64'(word_cnt), 4);
        chk("ovf_addr", 64'(mem_addr), 3);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (4) begin
            @(negedge clk);
            chk("ovf_rdy", 64'(s_ready), 0);
        end
        s_valid = 1'b0;
        do_start();

        // reset mid-word discards the partial bytes
        send_byte(8'h20, 1'b0, 0);
        send_byte(8'h08, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_cnt", 64'(word_cnt), 0);
        chk("mrst_we", 64'(mem_we), 0);
        chk("mrst_rdy", 64'(s_ready), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_addr = '0;
        xor_m    = '0;
        send_word(32'hDEAD_BEEF, 1'b1, 0);
        send_csum(xor_m);
        wait_end("mrst");
        chk("mrst_done", 64'(done), 1);
        chk("mrst_cnt1", 64'(word_cnt), 1);
        do_start();

`ifdef LOADER_CHECKSUM_EN
        send_word(32'h1111_1111, 1'b0, 0);
        send_word(32'h2222_2222, 1'b1, 0);
        send_csum(32'h3333_3333);
        wait_end("cs_ok");
        chk("cs_ok_done", 64'(done), 1);
        do_start();
        send_word(32'h1111_1111, 1'b0, 0);
        send_word(32'h2222_2222, 1'b1, 0);
        send_csum(32'h3333_3334);
        wait_end("cs_bad");
        chk("cs_bad_err", 64'(err), 1);
        chk("cs_bad_cpu", 64'(cpu_rst), 1);
`endif

        repeat (3) @(negedge clk);
        chk("final_q", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction-memory word-address width; capacity 2^ADDR_W words.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-004 Port s_valid, input, 1, SHALL indicate a valid program byte on s_data.
REQ-005 Port s_data, input, 8, SHALL carry the program byte.
REQ-006 Port s_last, input, 1, SHALL mark the final byte of the image; qualified by s_valid.
REQ-007 Port s_ready, output, 1, SHALL indicate the loader accepts a byte this cycle.
REQ-008 Port start, input, 1, SHALL request a new load; sampled only in DONE or ERR.
REQ-009 Port mem_we, output, 1, SHALL be the instruction-memory write strobe.
REQ-010 Port mem_addr, output, ADDR_W, SHALL be the instruction-memory word address.
REQ-011 Port mem_wdata, output, 32, SHALL be the instruction word to write.
REQ-012 Port cpu_rst, output, 1, SHALL hold the CPU PC in reset (active-high) while not DONE.
REQ-013 Port done, output, 1, SHALL be high in DONE.
REQ-014 Port err, output, 1, SHALL be high in ERR.
REQ-015 Port word_cnt, output, ADDR_W+1, SHALL report words written in the current load.

Function
REQ-016 States SHALL be LOAD, WRITE, DONE, ERR (plus CSUM when configured).
REQ-017 A byte SHALL transfer only in a cycle with s_valid and s_ready both high; s_ready SHALL be high only in LOAD and CSUM.
REQ-018 Byte order SHALL be big-endian: first byte to bits 31:24, fourth to 7:0.
REQ-019 On the fourth accepted byte, the FSM SHALL enter WRITE; in WRITE, mem_we SHALL be high for exactly one cycle with the assembled word and current address.
REQ-020 Address and word_cnt SHALL increment on the cycle after the WRITE cycle; WRITE SHALL then return to LOAD, or go to DONE if the fourth byte carried s_last.
REQ-021 s_last on byte 1, 2 or 3 of a word SHALL go to ERR; no write SHALL occur for the partial word.
REQ-022 A write to address 2^ADDR_W-1 without s_last SHALL complete, then go to ERR (overflow); the address SHALL NOT wrap.
REQ-023 In DONE, cpu_rst SHALL be 0; in all other states it SHALL be 1.
REQ-024 start in DONE or ERR SHALL go to LOAD with address, word_cnt and byte counter cleared; start in other states SHALL be ignored.
REQ-025 mem_we SHALL never be high outside WRITE.

Reset
REQ-026 While rst_n is low, state SHALL be LOAD and outputs SHALL be: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err=0, word_cnt=0; the byte counter SHALL be 0.
REQ-027 On the first clock edge after rst_n rises, s_ready SHALL become 1.
REQ-028 Reset mid-word or mid-WRITE SHALL discard the partial word with no write.

Configuration
REQ-029 With LOADER_CHECKSUM_EN defined, a byte with s_last set SHALL end the program words; four further bytes (CSUM state, no s_last required) SHALL form a checksum, which SHALL NOT be written; if it equals the XOR of all written words the FSM SHALL go to DONE, otherwise to ERR.
REQ-030 Without LOADER_CHECKSUM_EN, the CSUM state and XOR accumulator SHALL be absent, and behaviour SHALL be as REQ-020.

Structure
REQ-031 Package loader_pkg SHALL hold the state enumeration and the constants BYTE_W=8 and WORD_W=32.
REQ-032 Sub-module loader_shift SHALL hold the byte-to-word shift register and the 2-bit byte counter.

Verification
REQ-033 Bytes 20 08 00 05 then 01 09 50 20 (last) -> mem_we at addr 0 with 0x20080005, then addr 1 with 0x01095020; then done=1, cpu_rst=0, word_cnt=2.
REQ-034 s_valid toggled every other cycle -> words identical to the gap-free case, with no extra or missing mem_we.
REQ-035 Bytes AA BB with s_last on BB -> err=1, no mem_we, cpu_rst=1.
REQ-036 ADDR_W=2, 5 words with no s_last -> 4 writes to addr 0..3, then err=1, no fifth write.
REQ-037 rst_n pulsed low after 2 bytes, then a full word -> single write of the new word at addr 0; then start in DONE -> word_cnt=0, cpu_rst=1.
REQ-038 With LOADER_CHECKSUM_EN, words 0x11111111 and 0x22222222 followed by checksum 0x33333333 -> done=1; checksum 0x33333334 -> err=1.
